// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one single-port word memory.
// Define ARB_FIXED_PRIO_EN for fixed data-port priority; default is round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    // state   | meaning
    // S_IDLE  | waiting for a request, arbitrates
    // S_ISSUE | mem_en high for the latched access
    // S_WAIT  | counting down the read latency
    // S_DONE  | done pulse to the winner, no arbitration
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;        // 1 = data port
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              mem_en_q, mem_en_d;
    logic              busy_q, busy_d;
    logic              tie_data;
    logic              pick_data;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_data = 1'b1;
`else
    logic last_q, last_d;                   // 1 = data port served last
    assign tie_data = ~last_q;
`endif

    assign pick_data = d_req & (~i_req | tie_data);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        mem_en_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    win_d    = pick_data;
                    addr_d   = pick_data ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                    wdata_d  = pick_data ? d_wdata : 32'd0;
                    wmask_d  = pick_data ? d_wmask : 4'd0;
                    mem_en_d = 1'b1;
                    state_d  = S_ISSUE;
`ifndef ARB_FIXED_PRIO_EN
                    last_d   = pick_data;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = 3'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (win_q) begin
                        if (wmask_q == 4'd0) d_rdata_d = mem_rdata;
                        d_done_d = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_done_d  = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            win_q     <= 1'b0;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            mem_en_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            mem_en_q  <= mem_en_d;
            busy_q    <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at LATENCY=2 with a two-stage synchronous memory model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              i_req, d_req;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [31:0]       i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic              i_done, d_done, mem_en, busy;
    logic [3:0]        d_wmask, mem_wmask;
    logic [ADDR_W-3:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: data for an access appears LAT=2 cycles after mem_en, poison otherwise.
    logic [31:0] tb_mem [256];
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [7:0]  a1 = 8'd0, a2 = 8'd0;
    always @(posedge clk) begin
        p1 <= mem_en;
        a1 <= mem_addr[7:0];
        p2 <= p1;
        a2 <= a1;
    end
    assign mem_rdata = p2 ? tb_mem[a2] : 32'hBAD0_BAD0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          k_en, k_done, n_en, n_done;
    logic [29:0] en_addr;
    logic [31:0] en_wdata;
    logic [3:0]  en_wmask;

    // One request on one port, dropped in its DONE cycle; cycle k=0 is the grant cycle.
    task automatic single_access(input bit use_d);
        n_en = 0; n_done = 0; k_en = -1; k_done = -1;
        @(negedge clk);
        if (use_d) d_req = 1'b1; else i_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (k_en < 0) begin
                    k_en = k; en_addr = mem_addr; en_wdata = mem_wdata; en_wmask = mem_wmask;
                end
                n_en++;
            end
            if (use_d ? d_done : i_done) begin
                if (k_done < 0) k_done = k;
                n_done++;
                if (use_d) d_req = 1'b0; else i_req = 1'b0;
            end
            if (use_d ? i_done : d_done) n_done++;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    int   nd, nen, dk[4];
    logic dport[4];
    logic exp_port;

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'hA500_0000 | 32'(i);
        tb_mem[2] = 32'h0010_0093;
        resetn = 1'b0;
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;

        // Reset with toggling inputs
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_req = ~i_req; d_req = 1'b1; i_addr = $urandom; d_addr = $urandom;
            d_wdata = $urandom; d_wmask = 4'(k);
        end
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);
        i_req = 1'b0; d_req = 1'b0; d_wmask = 4'd0; d_wdata = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_mem_en", mem_en, 0);
        check("idle_outputs", {i_rdata, d_rdata, i_done, d_done, mem_addr, mem_wmask}, 0);

        // Both ports requesting continuously from the first tie after reset
        i_addr = 32'h20; d_addr = 32'h34;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; nd = 0; nen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_en) nen++;
            if (i_done || d_done) begin
                if (nd < 4) begin dport[nd] = d_done; dk[nd] = k; end
                nd++;
            end
            if (k == 19) begin i_req = 1'b0; d_req = 1'b0; end
        end
        check("alt_n_issue", nen, 4);
        check("alt_n_done", nd, 4);
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_port = 1'b1;
`else
            exp_port = n[0];
`endif
            check($sformatf("alt_port%0d", n), dport[n], exp_port);
            check($sformatf("alt_cycle%0d", n), dk[n], 3 + 5 * n);
        end
        repeat (2) @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
        check("alt_i_rdata", i_rdata, 32'h0);
`else
        check("alt_i_rdata", i_rdata, 32'hA500_0008);
`endif
        check("alt_d_rdata", d_rdata, 32'hA500_000D);

        // Fetch read
        i_addr = 32'h8;
        single_access(1'b0);
        check("fetch_k_en", k_en, 0);
        check("fetch_n_en", n_en, 1);
        check("fetch_addr", en_addr, 30'h2);
        check("fetch_wmask", en_wmask, 0);
        check("fetch_wdata", en_wdata, 0);
        check("fetch_k_done", k_done, 3);
        check("fetch_n_done", n_done, 1);
        check("fetch_rdata", i_rdata, 32'h0010_0093);
        check("fetch_busy_after", busy, 0);

        // Data write
        d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        single_access(1'b1);
        check("wr_k_en", k_en, 0);
        check("wr_n_en", n_en, 1);
        check("wr_addr", en_addr, 30'h41);
        check("wr_wdata", en_wdata, 32'hDEAD_BEEF);
        check("wr_wmask", en_wmask, 4'b0011);
        check("wr_k_done", k_done, 3);
        check("wr_n_done", n_done, 1);
        check("wr_d_rdata_kept", d_rdata, 32'hA500_000D);
        d_wmask = 4'd0; d_wdata = 32'd0;

        // Reset during WAIT
        i_addr = 32'h10;
        @(negedge clk);
        i_req = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy_wait", busy, 1);
        resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rdata", i_rdata, 0);
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_done || d_done) nd++;
        end
        check("midrst_no_done", nd, 0);
        single_access(1'b0);
        check("post_rst_k_en", k_en, 0);
        check("post_rst_k_done", k_done, 3);
        check("post_rst_n_done", n_done, 1);
        check("post_rst_rdata", i_rdata, 32'hA500_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the SOC's single-port word memory between the CPU instruction-fetch path and the CPU load/store path. It serialises accesses, drives one memory access at a time with a fixed read latency, and returns read data and a one-cycle completion pulse to the winning requester. It sits between the CPU state machine and `MEM`, replacing direct `MEM[PC[31:2]]` indexing once loads and stores are added.

## Interface
- `ADDR_W`, 32, byte-address width of both requester ports
- `LATENCY`, 1, cycles from `mem_en` high to `mem_rdata` valid; legal range 1..7
- `clk`  in  1  single system clock
- `resetn`  in  1  asynchronous, active-low reset
- `i_req`  in  1  instruction-fetch request, level, held until `i_done`
- `i_addr`  in  ADDR_W  fetch byte address; bits [1:0] ignored
- `i_rdata`  out  32  fetched word, registered
- `i_done`  out  1  one-cycle completion pulse for the fetch port
- `d_req`  in  1  data request, level, held until `d_done`
- `d_addr`  in  ADDR_W  data byte address; bits [1:0] ignored
- `d_wdata`  in  32  store data
- `d_wmask`  in  4  byte write enables; 0 means read
- `d_rdata`  out  32  load word, registered
- `d_done`  out  1  one-cycle completion pulse for the data port
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_addr`  out  ADDR_W-2  word address
- `mem_wdata`  out  32  write data
- `mem_wmask`  out  4  byte write enables
- `mem_rdata`  in  32  memory read data, valid LATENCY cycles after `mem_en`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any `req` is high, select a winner, latch its address, wdata and wmask (0 for the fetch port), and go to ISSUE. If no request is pending, remain in IDLE.
- ISSUE: lasts exactly one cycle. `mem_en`=1 and `mem_addr`/`mem_wdata`/`mem_wmask` are driven from the latched values. Load the counter with LATENCY-1, then go to WAIT.
- WAIT: decrement the 3-bit counter. When the counter reaches 0, sample `mem_rdata` at that edge into the winner's `rdata` (reads only) and go to DONE.
- DONE: lasts one cycle. The winner's `done`=1. No arbitration happens in DONE, so a requester that drops `req` at the end of the DONE cycle is never served twice.
- Writes:
  - Take the same path and latency as reads.
  - `d_rdata` is unchanged after a write.
- Fetch-port accesses always drive `mem_wmask`=0 and `mem_wdata`=0.
- Tie-break: round-robin on the `last` register. When both ports request, the port not served last wins. Reset value of `last` is "data", so the first tie after reset goes to fetch.
- A single request wins regardless of `last`. `last` is updated on every grant.
- `req` dropped mid-transaction: the access still completes and `done` still pulses. The requester must ignore that pulse.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, `last`=data, counter=0.
  - `mem_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
  - `i_rdata`=0, `d_rdata`=0, `i_done`=0, `d_done`=0, `busy`=0.
- Reset mid-access: the access is abandoned and no `done` fires after release.
- Single access latency: if `req` is sampled high at edge E0, then:
  - `mem_en` is high in cycle E0..E1.
  - `rdata` is captured at edge E(1+LATENCY).
  - `done` is high in cycle E(1+LATENCY)..E(2+LATENCY).
- Throughput: one access per LATENCY+3 cycles. `req` held high continuously is re-arbitrated in the IDLE cycle after DONE.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority. The data port always wins a tie and `last` is not implemented. The fetch port can starve under continuous data requests, which is acceptable for the multicycle CPU.
- `ARB_FIXED_PRIO_EN` undefined (default): round-robin as specified above.

## Test plan
- Reset: drive `resetn`=0 while inputs toggle -> every output is 0 and `busy`=0. After release, with no `req`, all outputs stay 0.
- Fetch read, LATENCY=2: `i_req`=1, `i_addr`=0x8, `mem_rdata`=0x00100093 -> `mem_en` for one cycle with `mem_addr`=0x2, `mem_wmask`=0. `i_done` pulses exactly 3 cycles after the grant edge and `i_rdata`=0x00100093.
- Data write: `d_addr`=0x104, `d_wdata`=0xDEADBEEF, `d_wmask`=4'b0011 -> `mem_addr`=0x41, `mem_wdata`=0xDEADBEEF, `mem_wmask`=0011 for one cycle. `d_done` pulses once and `d_rdata` is unchanged.
- Simultaneous first requests after reset -> fetch is served, then data. With `ARB_FIXED_PRIO_EN` -> data is served first.
- Both ports requesting continuously, LATENCY=1 -> grants alternate I,D,I,D. Successive `done` pulses are 4 cycles apart, with exactly one `done` per access.
- Assert `resetn`=0 during WAIT, then release -> no `done` pulse follows. A fresh `i_req` is served with nominal latency.
